// File: rtl/sc_reg_lfsr_gen_pkg.sv
// Shared definitions for the sampled LFSR generator.
// Holds the request-FSM state encoding, the legal parameter range, and the
// default maximal-length TAPS/SEED pairs for the widths in common use.
package sc_reg_lfsr_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } lfsr_fsm_e;

  localparam int WIDTH_MIN = 3;
  localparam int WIDTH_MAX = 16;

  localparam logic [3:0]  TAPS_W4  = 4'h9;
  localparam logic [3:0]  SEED_W4  = 4'h1;
  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [7:0]  SEED_W8  = 8'h01;
  localparam logic [15:0] TAPS_W16 = 16'hB400;
  localparam logic [15:0] SEED_W16 = 16'h0001;

  // Widths without a stored pair return 0, which the top rejects for SEED.
  function automatic logic [15:0] default_taps(input int width);
    if (width == 4)       return 16'(TAPS_W4);
    else if (width == 8)  return 16'(TAPS_W8);
    else if (width == 16) return TAPS_W16;
    else                  return '0;
  endfunction

  function automatic logic [15:0] default_seed(input int width);
    if (width == 4)       return 16'(SEED_W4);
    else if (width == 8)  return 16'(SEED_W8);
    else if (width == 16) return SEED_W16;
    else                  return '0;
  endfunction

endpackage

// File: rtl/sc_reg_lfsr_gen_step.sv
// Combinational Fibonacci LFSR step: left shift, XOR of tapped bits into bit 0.
// Ports:
//   state_in   - current LFSR state
//   state_next - state after one shift
module sc_lfsr_step #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = '0
) (
  input  logic [WIDTH-1:0] state_in,
  output logic [WIDTH-1:0] state_next
);

  logic feedback;

  assign feedback   = ^(state_in & TAPS);
  assign state_next = {state_in[WIDTH-2:0], feedback};

endmodule

// File: rtl/sc_reg_lfsr_gen.sv
// Sampled LFSR generator with free-run and request modes.
// Ports:
//   SC_RegSHIFTER_CLOCK_50     - rising-edge clock
//   SC_RegSHIFTER_RESET_InHigh - async active-high reset
//   enable     - advance permit; low freezes state, counter and FSM
//   free_run   - 1: shift and sample every enabled cycle; 0: shift on req
//   seed_load  - load seed_in (0 maps to SEED) into state and active seed
//   seed_in    - seed value for seed_load
//   req        - sample request in request mode
//   busy       - request in progress
//   valid      - one-cycle pulse, data_out updated
//   data_out   - latched low OUT_WIDTH bits of the state
//   state_out  - current LFSR state
//   wrap       - one-cycle pulse, a shift returned to the active seed
//   lockup     - one-cycle pulse, all-zero state replaced by active seed
//
// state   | meaning
// IDLE    | waiting for req; also held here in free-run mode
// SHIFT   | performing OUT_WIDTH shifts, one per enabled cycle
// DONE    | latch data_out, pulse valid, return to IDLE
module sc_reg_lfsr_gen
  import sc_reg_lfsr_gen_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               OUT_WIDTH = 3,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED      = WIDTH'(default_seed(WIDTH))
) (
  input  logic                 SC_RegSHIFTER_CLOCK_50,
  input  logic                 SC_RegSHIFTER_RESET_InHigh,
  input  logic                 enable,
  input  logic                 free_run,
  input  logic                 seed_load,
  input  logic [WIDTH-1:0]     seed_in,
  input  logic                 req,
  output logic                 busy,
  output logic                 valid,
  output logic [OUT_WIDTH-1:0] data_out,
  output logic [WIDTH-1:0]     state_out,
  output logic                 wrap,
  output logic                 lockup
);

  localparam int CNT_W = $clog2(WIDTH_MAX) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_WIDTH - 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("sc_reg_lfsr_gen: WIDTH outside 3..16");
  end
  if (OUT_WIDTH < 1 || OUT_WIDTH > WIDTH) begin : g_bad_out_width
    $error("sc_reg_lfsr_gen: OUT_WIDTH outside 1..WIDTH");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("sc_reg_lfsr_gen: SEED must be non-zero");
  end

  lfsr_fsm_e            fsm_q, fsm_d;
  logic [WIDTH-1:0]     state_q, state_d;
  logic [WIDTH-1:0]     seed_q, seed_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 wrap_q, wrap_d;
  logic                 lockup_q, lockup_d;

  logic [WIDTH-1:0]     step;
  logic [WIDTH-1:0]     seed_eff;
  logic                 zero;

  sc_lfsr_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_step (
    .state_in   (state_q),
    .state_next (step)
  );

  assign seed_eff = (seed_in == '0) ? SEED : seed_in;
  assign zero     = (state_q == '0);

  always_comb begin
    fsm_d    = fsm_q;
    state_d  = state_q;
    seed_d   = seed_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    wrap_d   = 1'b0;
    lockup_d = 1'b0;

    if (seed_load) begin
      state_d = seed_eff;
      seed_d  = seed_eff;
      fsm_d   = ST_IDLE;
      cnt_d   = '0;
    end else if (enable) begin
      if (zero) begin
        // Recovery replaces the shift for this cycle.
        state_d  = seed_q;
        lockup_d = 1'b1;
      end

      if (free_run) begin
        fsm_d = ST_IDLE;
        cnt_d = '0;
        // The cycle that aborts a pending request neither shifts nor samples.
        if (fsm_q == ST_IDLE && !zero) begin
          state_d = step;
          data_d  = step[OUT_WIDTH-1:0];
          valid_d = 1'b1;
          wrap_d  = (step == seed_q);
        end
      end else begin
        unique case (fsm_q)
          ST_IDLE: begin
            if (req) begin
              fsm_d = ST_SHIFT;
              cnt_d = '0;
            end
          end
          ST_SHIFT: begin
            if (!zero) begin
              state_d = step;
              wrap_d  = (step == seed_q);
              if (cnt_q == CNT_LAST) begin
                fsm_d = ST_DONE;
                cnt_d = '0;
              end else begin
                cnt_d = cnt_q + CNT_W'(1);
              end
            end
          end
          ST_DONE: begin
            data_d  = state_q[OUT_WIDTH-1:0];
            valid_d = 1'b1;
            fsm_d   = ST_IDLE;
          end
          default: fsm_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge SC_RegSHIFTER_CLOCK_50 or posedge SC_RegSHIFTER_RESET_InHigh) begin
    if (SC_RegSHIFTER_RESET_InHigh) begin
      fsm_q    <= ST_IDLE;
      state_q  <= SEED;
      seed_q   <= SEED;
      cnt_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      state_q  <= state_d;
      seed_q   <= seed_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      wrap_q   <= wrap_d;
      lockup_q <= lockup_d;
    end
  end

  assign busy      = (fsm_q != ST_IDLE);
  assign valid     = valid_q;
  assign data_out  = data_q;
  assign state_out = state_q;
  assign wrap      = wrap_q;
  assign lockup    = lockup_q;

endmodule

// File: tb/tb_sc_reg_lfsr_gen.sv
// Directed bench for sc_reg_lfsr_gen: a per-cycle vector table for request
// mode, seed load, enable stalls and free-run abort, then hand sequences for
// reset mid-request, the 255-cycle free-run wrap and all-zero recovery.
module tb_sc_reg_lfsr_gen;

  typedef struct {
    logic       sl;
    logic [7:0] si;
    logic       rq;
    logic       en;
    logic       fr;
    logic       bsy;
    logic       vld;
    logic [2:0] dat;
    logic [7:0] st;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0, free_run = 1'b0, seed_load = 1'b0, req = 1'b0;
  logic [7:0] seed_in = 8'h00;
  logic       busy, valid, wrap, lockup;
  logic [2:0] data_out;
  logic [7:0] state_out;

  logic       en2 = 1'b0, fr2 = 1'b0, sl2 = 1'b0, req2 = 1'b0;
  logic [2:0] seed_in2 = 3'b000;
  logic       busy2, valid2, wrap2, lockup2;
  logic [2:0] data2, state2;

  int errors = 0;
  int checks = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  sc_reg_lfsr_gen #(
    .WIDTH(8), .OUT_WIDTH(3), .TAPS(8'hB8), .SEED(8'h01)
  ) dut (
    .SC_RegSHIFTER_CLOCK_50     (clk),
    .SC_RegSHIFTER_RESET_InHigh (rst),
    .enable    (enable),
    .free_run  (free_run),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .req       (req),
    .busy      (busy),
    .valid     (valid),
    .data_out  (data_out),
    .state_out (state_out),
    .wrap      (wrap),
    .lockup    (lockup)
  );

  // No feedback taps: 001 -> 010 -> 100 -> 000 forces a lockup.
  sc_reg_lfsr_gen #(
    .WIDTH(3), .OUT_WIDTH(3), .TAPS(3'b000), .SEED(3'b001)
  ) dut_zero (
    .SC_RegSHIFTER_CLOCK_50     (clk),
    .SC_RegSHIFTER_RESET_InHigh (rst),
    .enable    (en2),
    .free_run  (fr2),
    .seed_load (sl2),
    .seed_in   (seed_in2),
    .req       (req2),
    .busy      (busy2),
    .valid     (valid2),
    .data_out  (data2),
    .state_out (state2),
    .wrap      (wrap2),
    .lockup    (lockup2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic sl, input logic [7:0] si, input logic rq,
                     input logic en, input logic fr, input logic bsy,
                     input logic vld, input logic [2:0] dat, input logic [7:0] st);
    vec_t v;
    v.sl = sl; v.si = si; v.rq = rq; v.en = en; v.fr = fr;
    v.bsy = bsy; v.vld = vld; v.dat = dat; v.st = st;
    vq.push_back(v);
  endtask

  initial begin
    int vcnt, wcnt, wpos, lcnt;

    //  sl  si     rq  en  fr   busy vld dat     state
    // first request from reset seed: 01 -> 02 -> 04 -> 08, valid at t+4
    add(0, 8'h00, 1, 1, 0,   1, 0, 3'b000, 8'h01);
    add(0, 8'h00, 0, 1, 0,   1, 0, 3'b000, 8'h02);
    add(0, 8'h00, 0, 1, 0,   1, 0, 3'b000, 8'h04);
    add(0, 8'h00, 0, 1, 0,   1, 0, 3'b000, 8'h08);
    add(0, 8'h00, 0, 1, 0,   0, 1, 3'b000, 8'h08);
    // second request 08 -> 11 -> 23 -> 47, extra req while busy ignored
    add(0, 8'h00, 1, 1, 0,   1, 0, 3'b000, 8'h08);
    add(0, 8'h00, 1, 1, 0,   1, 0, 3'b000, 8'h11);
    add(0, 8'h00, 0, 1, 0,   1, 0, 3'b000, 8'h23);
    add(0, 8'h00, 0, 1, 0,   1, 0, 3'b000, 8'h47);
    add(0, 8'h00, 0, 1, 0,   0, 1, 3'b111, 8'h47);
    add(0, 8'h00, 0, 1, 0,   0, 0, 3'b111, 8'h47);
    // seed_load of 0 mid-request falls back to SEED, then a clean request
    add(0, 8'h00, 1, 1, 0,   1, 0, 3'b111, 8'h47);
    add(0, 8'h00, 0, 1, 0,   1, 0, 3'b111, 8'h8E);
    add(1, 8'h00, 0, 1, 0,   0, 0, 3'b111, 8'h01);
    add(0, 8'h00, 1, 1, 0,   1, 0, 3'b111, 8'h01);
    add(0, 8'h00, 0, 1, 0,   1, 0, 3'b111, 8'h02);
    add(0, 8'h00, 0, 1, 0,   1, 0, 3'b111, 8'h04);
    add(0, 8'h00, 0, 1, 0,   1, 0, 3'b111, 8'h08);
    add(0, 8'h00, 0, 1, 0,   0, 1, 3'b000, 8'h08);
    // seed_load acts with enable low
    add(1, 8'h00, 0, 0, 0,   0, 0, 3'b000, 8'h01);
    // two enable-low cycles inside SHIFT push valid to t+6
    add(0, 8'h00, 1, 1, 0,   1, 0, 3'b000, 8'h01);
    add(0, 8'h00, 0, 1, 0,   1, 0, 3'b000, 8'h02);
    add(0, 8'h00, 0, 0, 0,   1, 0, 3'b000, 8'h02);
    add(0, 8'h00, 0, 0, 0,   1, 0, 3'b000, 8'h02);
    add(0, 8'h00, 0, 1, 0,   1, 0, 3'b000, 8'h04);
    add(0, 8'h00, 0, 1, 0,   1, 0, 3'b000, 8'h08);
    add(0, 8'h00, 0, 1, 0,   0, 1, 3'b000, 8'h08);
    // free_run rises mid-request: abort without valid, then free-run samples
    add(0, 8'h00, 1, 1, 0,   1, 0, 3'b000, 8'h08);
    add(0, 8'h00, 0, 1, 0,   1, 0, 3'b000, 8'h11);
    add(0, 8'h00, 0, 1, 1,   0, 0, 3'b000, 8'h11);
    add(0, 8'h00, 0, 1, 1,   0, 1, 3'b011, 8'h23);
    add(0, 8'h00, 1, 1, 1,   0, 1, 3'b111, 8'h47);
    add(0, 8'h00, 0, 1, 0,   0, 0, 3'b111, 8'h47);
    add(0, 8'h00, 0, 0, 1,   0, 0, 3'b111, 8'h47);
    // explicit seed, then one free-run shift 5A -> B4
    add(1, 8'h5A, 0, 0, 0,   0, 0, 3'b111, 8'h5A);
    add(0, 8'h00, 0, 1, 1,   0, 1, 3'b100, 8'hB4);
    add(0, 8'h00, 0, 1, 0,   0, 0, 3'b100, 8'hB4);

    // reset values while reset is held
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 32'(state_out), 32'h01);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_wrap", 32'(wrap), 0);
    chk("rst_lockup", 32'(lockup), 0);
    chk("rst_state2", 32'(state2), 32'h1);
    rst = 1'b0;

    foreach (vq[i]) begin
      seed_load = vq[i].sl;
      seed_in   = vq[i].si;
      req       = vq[i].rq;
      enable    = vq[i].en;
      free_run  = vq[i].fr;
      tick();
      chk($sformatf("v%0d_busy", i),   32'(busy),      32'(vq[i].bsy));
      chk($sformatf("v%0d_valid", i),  32'(valid),     32'(vq[i].vld));
      chk($sformatf("v%0d_data", i),   32'(data_out),  32'(vq[i].dat));
      chk($sformatf("v%0d_state", i),  32'(state_out), 32'(vq[i].st));
      chk($sformatf("v%0d_wrap", i),   32'(wrap),      0);
      chk($sformatf("v%0d_lockup", i), 32'(lockup),    0);
    end
    seed_load = 1'b0;
    free_run  = 1'b0;
    enable    = 1'b1;

    // reset asserted mid-request acts immediately and discards the request
    req = 1'b1;
    tick();
    req = 1'b0;
    chk("mid_busy", 32'(busy), 1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_state", 32'(state_out), 32'h01);
    chk("arst_data", 32'(data_out), 0);
    tick();
    rst = 1'b0;
    vcnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (valid) vcnt++;
    end
    chk("post_rst_valids", 32'(vcnt), 0);
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_state", 32'(state_out), 32'h01);

    // 255 free-run cycles from 01: 255 valids, one wrap right after the last shift
    free_run = 1'b1;
    vcnt = 0; wcnt = 0; wpos = 0;
    for (int k = 1; k <= 255; k++) begin
      tick();
      if (valid) vcnt++;
      if (wrap) begin
        wcnt++;
        wpos = k;
      end
    end
    enable = 1'b0;
    chk("fr_valid_count", 32'(vcnt), 255);
    chk("fr_wrap_count", 32'(wcnt), 1);
    chk("fr_wrap_pos", 32'(wpos), 255);
    chk("fr_state", 32'(state_out), 32'h01);
    tick();
    chk("freeze_valid", 32'(valid), 0);
    chk("freeze_wrap", 32'(wrap), 0);
    chk("freeze_state", 32'(state_out), 32'h01);

    // all-zero recovery on the no-tap instance
    en2 = 1'b1;
    fr2 = 1'b1;
    lcnt = 0;
    tick();
    chk("lk1_state", 32'(state2), 32'h2);
    chk("lk1_valid", 32'(valid2), 1);
    if (lockup2) lcnt++;
    tick();
    chk("lk2_state", 32'(state2), 32'h4);
    if (lockup2) lcnt++;
    tick();
    chk("lk3_state", 32'(state2), 32'h0);
    chk("lk3_data", 32'(data2), 32'h0);
    if (lockup2) lcnt++;
    tick();
    chk("lk4_state", 32'(state2), 32'h1);
    chk("lk4_lockup", 32'(lockup2), 1);
    chk("lk4_valid", 32'(valid2), 0);
    if (lockup2) lcnt++;
    en2 = 1'b0;
    tick();
    chk("lk5_lockup", 32'(lockup2), 0);
    chk("lk5_state", 32'(state2), 32'h1);
    chk("lk_count", 32'(lcnt), 1);
    chk("lk_busy", 32'(busy2), 0);
    chk("lk_wrap", 32'(wrap2), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sc_reg_lfsr_gen.md
SC_REG_LFSR_GEN -- requirements
Module: sc_reg_lfsr_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- WIDTH, 8, LFSR state width, legal 3..16.
- OUT_WIDTH, 3, sample width, legal 1..WIDTH.
- TAPS, 8'hB8, feedback mask; bit i set means state[i] enters the XOR.
- SEED, 8'h01, non-zero reset and fallback seed.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- SC_RegSHIFTER_CLOCK_50, in, 1, rising-edge clock.
- SC_RegSHIFTER_RESET_InHigh, in, 1, reset; asynchronous, active-high.
- enable, in, 1, shift/FSM advance permit; low freezes all state.
- free_run, in, 1, 1 = shift every enabled cycle; 0 = shift on request.
- seed_load, in, 1, one-cycle load strobe.
- seed_in, in, WIDTH, seed value for load.
- req, in, 1, one-cycle sample request (request mode).
- busy, out, 1, request in progress.
- valid, out, 1, one-cycle pulse: new data_out.
- data_out, out, OUT_WIDTH, latched sample = state[OUT_WIDTH-1:0].
- state_out, out, WIDTH, current LFSR state.
- wrap, out, 1, one-cycle pulse: state returned to active seed.
- lockup, out, 1, one-cycle pulse: all-zero state recovered.

Function
REQ-003 A shift SHALL be Fibonacci left-shift: next = {state[WIDTH-2:0], XOR-reduce(state AND TAPS)}.
REQ-004 The active seed register SHALL hold the last accepted seed; seed_in == 0 SHALL be replaced by SEED.
REQ-005 seed_load SHALL have top priority, independent of enable: state and active seed take the seed; FSM goes to IDLE; no valid or wrap that cycle.
REQ-006 Request-mode FSM states SHALL be IDLE, SHIFT, DONE.
REQ-007 IDLE->SHIFT on req=1 with enable=1 and free_run=0; shift counter cleared; busy=1 from the next cycle.
REQ-008 SHIFT SHALL perform exactly OUT_WIDTH shifts, one per enabled cycle, then go to DONE.
REQ-009 DONE SHALL latch data_out from state[OUT_WIDTH-1:0], pulse valid for one cycle, drop busy, and return to IDLE.
REQ-010 Latency: req accepted at edge t gives valid high during cycle t+OUT_WIDTH+1 when enable stays high; each enable-low cycle adds one cycle.
REQ-011 req while busy, or while free_run=1, SHALL be ignored (no queueing).
REQ-012 Free-run (free_run=1, enable=1): one shift per cycle; data_out latched from the post-shift state with valid pulsed every cycle; FSM held in IDLE.
REQ-013 Changing free_run to 1 mid-request SHALL abort the request: FSM to IDLE, busy=0, no valid.
REQ-014 wrap SHALL pulse on the cycle after a shift whose result equals the active seed.
REQ-015 If state == 0 after any shift, the next edge SHALL reload the active seed and pulse lockup for one cycle; this costs one cycle of latency.
REQ-016 enable=0 SHALL freeze state, counter, and FSM; valid, wrap, and lockup stay 0.

Reset
REQ-017 During reset: state = active seed = SEED, FSM = IDLE, counter = 0, data_out = 0, busy = valid = wrap = lockup = 0.
REQ-018 Reset SHALL act asynchronously and release synchronously to SC_RegSHIFTER_CLOCK_50; reset mid-request discards the request.

Structure
REQ-019 A shared package SHALL hold the FSM state encoding, the default TAPS/SEED pairs for WIDTH 4, 8, and 16 (4'h9/4'h1, 8'hB8/8'h01, 16'hB400/16'h0001), and the legal-range constants.
REQ-020 The shift-plus-feedback datapath SHALL be a sub-module named sc_lfsr_step (combinational next-state function); the FSM, counter, and flags SHALL live in the top module.
REQ-021 Illegal parameters (SEED == 0, OUT_WIDTH > WIDTH) SHALL be rejected at elaboration.

Verification (WIDTH=8, TAPS=8'hB8, SEED=8'h01, OUT_WIDTH=3)
REQ-022 After reset, first req -> busy for 3 shifts; state_out 01->02->04->08; valid at t+4; data_out = 3'b000.
REQ-023 Second req -> state 08->11->23->47; data_out = 3'b111; one valid pulse only.
REQ-024 Free-run from 8'h01 for 255 enabled cycles -> wrap pulses exactly once, on the cycle after the 255th shift; 255 valid pulses.
REQ-025 seed_load with seed_in = 0 mid-request -> state = 01, busy = 0, no valid; a subsequent req behaves as in REQ-022.
REQ-026 Toggle enable low for 2 cycles during SHIFT -> valid delayed to t+6; data_out unchanged versus REQ-022.
REQ-027 Force the all-zero state (TAPS = 0 variant, 3 shifts from 01 then zero) -> lockup pulse once, state_out returns to 01.
